spi_rx_word_fifo: RTL

Receive-side buffer placed directly downstream of `spi_slave`. It accepts the byte stream the slave produces on its `data_out` / `write_en` / `is_full` write port and stores it in a byte-wide circular buffer. It presents the oldest three bytes as one 24-bit word to the application logic, with a pop handshake. It runs on the same clock as the slave's write port, so the FIFO needs no clock-domain crossing.

---
 rtl/spi_rx_word_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/spi_rx_word_fifo.sv
// Byte-wide circular receive buffer behind spi_slave. It presents the three
// oldest bytes as one show-ahead 24-bit word, MSB first, with a pop handshake.
module spi_rx_word_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          SCLK,
  input  logic          RSTn,
  input  logic [7:0]    data_in,
  input  logic          write_en,
  output logic          is_full,
  output logic [23:0]   word_out,
  output logic          word_valid,
  input  logic          word_read,
  input  logic          clear,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] WORD_CNT = (AW+1)'(3);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          has_word;
  logic          pop;
  logic          push;
  logic          mem_we;
  logic [AW-1:0] rp_p1, rp_p2;

  logic signed [AW+1:0] cnt_cur_s, cnt_inc_s, cnt_dec_s, cnt_nxt_s;

  // Handshake decode; a push into a full buffer is allowed when a pop frees room
  always_comb begin
    has_word = (count_q >= WORD_CNT);
    pop      = word_read && has_word;
    push     = write_en && ((count_q < FULL_CNT) || pop);
    mem_we   = push && !clear;
  end

  // Occupancy update, done signed one bit wider so push/pop never wraps
  always_comb begin
    cnt_cur_s = signed'({1'b0, count_q});
    cnt_inc_s = push ? (AW+2)'(1) : '0;
    cnt_dec_s = pop  ? (AW+2)'(3) : '0;
    cnt_nxt_s = cnt_cur_s + cnt_inc_s - cnt_dec_s;
  end

  // Next-state logic; clear overrides every other update
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clear) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(3);
      count_d = (AW+1)'(unsigned'(cnt_nxt_s));
      if (write_en && !push)     ovf_d = 1'b1;
      if (word_read && !has_word) unf_d = 1'b1;
    end
  end

  always_ff @(posedge SCLK or negedge RSTn) begin
    if (!RSTn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Byte storage; only reset wipes it, clear leaves contents in place
  always_ff @(posedge SCLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wp_q] <= data_in;
    end
  end

  // Show-ahead word, straddling the buffer end without a bubble
  always_comb begin
    rp_p1    = rp_q + AW'(1);
    rp_p2    = rp_q + AW'(2);
    word_out = {mem_q[rp_q], mem_q[rp_p1], mem_q[rp_p2]};
  end

  assign count      = count_q;
  assign is_full    = (count_q == FULL_CNT);
  assign word_valid = has_word;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule
